vx_raster_stamp_rsp: RTL and testbench

Consumer-side endpoint of the rasterizer stamp stream. Accepts `raster_stamp_t` quads from the raster unit and hands them out, one stamp per active thread, in response to a core raster-fetch request. It stores each delivered stamp in per-warp, per-lane CSR storage in `raster_csrs_t` layout and serves single-cycle CSR reads of that storage. It sits between the raster unit output and the core's raster CSR/instruction path.

---
 rtl/vx_raster_stamp_rsp.sv | 168 ++++++++++++++++
 tb/tb_vx_raster_stamp_rsp.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_raster_stamp_rsp.sv
// Raster stamp response endpoint: hands out one queued stamp per active thread on a fetch
// request, keeps the delivered stamps as per-warp/per-lane raster CSRs and serves CSR reads.
module vx_raster_stamp_rsp #(
    parameter int NUM_WARPS  = 4,
    parameter int NUM_LANES  = 4,
    parameter int TAG_WIDTH  = 8,
    localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int NL_BITS    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int DIM_BITS   = 15,
    localparam int PID_BITS   = 6,
    localparam int STAMP_BITS = 2 * (DIM_BITS - 1) + 4 + 12 * 32 + PID_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stamp_valid,
    input  logic [STAMP_BITS-1:0]   stamp_data,
    input  logic                    stamp_done,
    output logic                    stamp_ready,
    input  logic                    req_valid,
    input  logic [NW_BITS-1:0]      req_wid,
    input  logic [NUM_LANES-1:0]    req_tmask,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    output logic                    req_ready,
    output logic                    rsp_valid,
    output logic [NW_BITS-1:0]      rsp_wid,
    output logic [NUM_LANES-1:0]    rsp_tmask,
    output logic [TAG_WIDTH-1:0]    rsp_tag,
    output logic [NUM_LANES*32-1:0] rsp_data,
    input  logic                    rsp_ready,
    input  logic [NW_BITS-1:0]      csr_read_wid,
    input  logic [NL_BITS-1:0]      csr_read_lane,
    input  logic [3:0]              csr_read_idx,
    output logic [31:0]             csr_read_data
);

    typedef struct packed {
        logic [DIM_BITS-2:0]     pos_x;
        logic [DIM_BITS-2:0]     pos_y;
        logic [3:0]              mask;
        logic [2:0][3:0][31:0]   bcoords;
        logic [PID_BITS-1:0]     pid;
    } raster_stamp_t;

    typedef struct packed {
        logic [31:0]             pos_mask;
        logic [2:0][3:0][31:0]   bcoords;
    } raster_csrs_t;

    typedef enum logic [1:0] {IDLE, FETCH, RSP} state_t;

    state_t                 state;
    logic [NUM_LANES-1:0]   remaining;
    logic [NUM_LANES-1:0]   rsp_mask;
    raster_csrs_t           csrs [NUM_WARPS][NUM_LANES];

    raster_stamp_t          stamp;
    logic                   pid_unused;
    logic [NL_BITS-1:0]     cur_lane;
    logic [NUM_LANES-1:0]   lane_onehot;
    logic                   lane_found;
    logic [31:0]            new_pos_mask;
    raster_csrs_t           rd_entry;
    logic [3:0]             bidx;

    assign stamp      = raster_stamp_t'(stamp_data);
    assign pid_unused = ^stamp.pid;

    assign req_ready   = !reset && (state == IDLE);
    assign rsp_valid   = !reset && (state == RSP);
    assign stamp_ready = !reset && (state == FETCH) && (remaining != '0) && stamp_valid;

    // Lowest pending lane is served first.
    always_comb begin
        cur_lane    = '0;
        lane_onehot = '0;
        lane_found  = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (remaining[i] && !lane_found) begin
                cur_lane       = NL_BITS'(i);
                lane_onehot[i] = 1'b1;
                lane_found     = 1'b1;
            end
        end
    end

    always_comb begin
        new_pos_mask                              = '0;
        new_pos_mask[3:0]                         = stamp.mask;
        new_pos_mask[4 +: DIM_BITS-1]             = stamp.pos_x;
        new_pos_mask[3+DIM_BITS +: DIM_BITS-1]    = stamp.pos_y;
    end

    always_comb begin
        rsp_data = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            rsp_data[i*32] = rsp_mask[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            rsp_mask  <= '0;
            rsp_wid   <= '0;
            rsp_tmask <= '0;
            rsp_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_wid   <= req_wid;
                        rsp_tmask <= req_tmask;
                        rsp_tag   <= req_tag;
                        remaining <= req_tmask;
                        rsp_mask  <= '0;
                        state     <= (req_tmask != '0) ? FETCH : RSP;
                    end
                end
                FETCH: begin
                    if ((remaining != '0) && (stamp_valid || stamp_done)) begin
                        remaining <= remaining & ~lane_onehot;
                        if (stamp_valid) begin
                            rsp_mask[cur_lane] <= 1'b1;
                        end
                        if ((remaining & ~lane_onehot) == '0) begin
                            state <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                for (int unsigned l = 0; l < NUM_LANES; l++) begin
                    csrs[w][l] <= '0;
                end
            end
        end else if (stamp_ready) begin
            csrs[rsp_wid][cur_lane] <= '{pos_mask: new_pos_mask, bcoords: stamp.bcoords};
        end
    end

    // Index 1..12 maps to bcoords[i][j] with idx-1 = 4*i + j.
    always_comb begin
        csr_read_data = '0;
        rd_entry      = '0;
        bidx          = csr_read_idx - 4'd1;
        if ((int'(csr_read_wid) < NUM_WARPS) && (int'(csr_read_lane) < NUM_LANES)) begin
            rd_entry = csrs[csr_read_wid][csr_read_lane];
        end
        if (csr_read_idx == 4'd0) begin
            csr_read_data = rd_entry.pos_mask;
        end else if (csr_read_idx <= 4'd12) begin
            csr_read_data = rd_entry.bcoords[bidx[3:2]][bidx[1:0]];
        end
    end

endmodule

// File: tb/tb_vx_raster_stamp_rsp.sv
// Randomized self-checking bench for vx_raster_stamp_rsp against a transaction-level model
// of stamp distribution and the per-warp/per-lane CSR contents.
module tb_vx_raster_stamp_rsp;

    localparam int NW = 4;
    localparam int NL = 4;
    localparam int TW = 8;
    localparam int SW = 2 * 14 + 4 + 12 * 32 + 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            stamp_valid;
    logic [SW-1:0]   stamp_data;
    logic            stamp_done;
    logic            stamp_ready;
    logic            req_valid;
    logic [1:0]      req_wid;
    logic [NL-1:0]   req_tmask;
    logic [TW-1:0]   req_tag;
    logic            req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_wid;
    logic [NL-1:0]   rsp_tmask;
    logic [TW-1:0]   rsp_tag;
    logic [NL*32-1:0] rsp_data;
    logic            rsp_ready;
    logic [1:0]      csr_read_wid;
    logic [1:0]      csr_read_lane;
    logic [3:0]      csr_read_idx;
    logic [31:0]     csr_read_data;

    vx_raster_stamp_rsp #(
        .NUM_WARPS (NW),
        .NUM_LANES (NL),
        .TAG_WIDTH (TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stamp_valid   (stamp_valid),
        .stamp_data    (stamp_data),
        .stamp_done    (stamp_done),
        .stamp_ready   (stamp_ready),
        .req_valid     (req_valid),
        .req_wid       (req_wid),
        .req_tmask     (req_tmask),
        .req_tag       (req_tag),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_wid       (rsp_wid),
        .rsp_tmask     (rsp_tmask),
        .rsp_tag       (rsp_tag),
        .rsp_data      (rsp_data),
        .rsp_ready     (rsp_ready),
        .csr_read_wid  (csr_read_wid),
        .csr_read_lane (csr_read_lane),
        .csr_read_idx  (csr_read_idx),
        .csr_read_data (csr_read_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [SW-1:0] q[$];
    logic [31:0]   m_csr [NW][NL][16];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] mk_stamp(input logic [13:0] px, input logic [13:0] py,
                                                input logic [3:0] mk);
        logic [2:0][3:0][31:0] bc;
        for (int k = 0; k < 12; k++) bc[k/4][k%4] = $urandom;
        return {px, py, mk, bc, 6'($urandom)};
    endfunction

    // Stamp layout: pos_x[421:408], pos_y[407:394], mask[393:390], bcoords[389:6], pid[5:0].
    task automatic model_write(input int w, input int l, input logic [SW-1:0] s);
        m_csr[w][l][0] = {s[407:394], s[421:408], s[393:390]};
        for (int k = 0; k < 12; k++) m_csr[w][l][1+k] = s[6 + k*32 +: 32];
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++)
            for (int l = 0; l < NL; l++)
                for (int i = 0; i < 16; i++) m_csr[w][l][i] = '0;
    endtask

    task automatic csr_sweep();
        for (int w = 0; w < NW; w++)
            for (int l = 0; l < NL; l++)
                for (int i = 0; i < 16; i++) begin
                    csr_read_wid  = 2'(w);
                    csr_read_lane = 2'(l);
                    csr_read_idx  = 4'(i);
                    #1 check("csr_read", csr_read_data, m_csr[w][l][i]);
                end
    endtask

    // One request: stamps come from q in order, one per active lane (ascending), and once
    // q is empty the stream reports done so the remaining lanes get no stamp.
    task automatic run_req(input int w, input logic [3:0] tm, input bit rgaps, input int st_at,
                           input int st_len, input int hold, input int rst_after);
        int lanes[$];
        int nst, used, k, lat, stalls, pops, fc, cur;
        bit sv;
        logic [127:0] exp_data;
        logic [7:0] tag;
        nst = q.size();
        used = 0;
        exp_data = '0;
        for (int l = 0; l < NL; l++) begin
            if (tm[l]) begin
                lanes.push_back(l);
                if (used < nst) begin
                    exp_data[l*32] = 1'b1;
                    used++;
                end
            end
        end
        k = lanes.size();
        @(negedge clk);
        tag = 8'($urandom);
        req_valid = 1'b1; req_wid = 2'(w); req_tmask = tm; req_tag = tag;
        stamp_valid = 1'b0; stamp_done = 1'b0;
        #1 check("req_ready_idle", req_ready, 1);
        @(posedge clk);
        lat = 0; stalls = 0; pops = 0;
        forever begin
            @(negedge clk);
            req_valid = 1'b0; req_tmask = 4'($urandom); req_wid = 2'($urandom); req_tag = 8'($urandom);
            lat++;
            if (rst_after > 0 && pops == rst_after) begin
                reset = 1'b1;
                stamp_valid = (q.size() > 0);
                if (q.size() > 0) stamp_data = q[0];
                stamp_done = 1'b0;
                #1 check("rst_stamp_ready", stamp_ready, 0);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_req_ready", req_ready, 0);
                @(posedge clk);
                #1 reset = 1'b0;
                model_reset();
                q.delete();
                @(negedge clk);
                stamp_valid = 1'b0;
                #1 check("post_rst_rsp_valid", rsp_valid, 0);
                check("post_rst_req_ready", req_ready, 1);
                csr_sweep();
                return;
            end
            #1;
            if (rsp_valid) break;
            if (lat > 200) begin
                check("rsp_timeout", 0, 1);
                return;
            end
            fc = lat - 1;
            if (rgaps) sv = ($urandom_range(0, 3) != 0);
            else       sv = !(fc >= st_at && fc < st_at + st_len);
            stamp_valid = (q.size() > 0) && sv;
            stamp_done  = (q.size() == 0);
            if (q.size() > 0) stamp_data = q[0];
            cur = (lanes.size() > 0) ? lanes[0] : 0;
            csr_read_wid = 2'(w); csr_read_lane = 2'(cur); csr_read_idx = 4'd0;
            #1 check("stamp_ready", stamp_ready, stamp_valid && (lanes.size() > 0));
            if (stamp_ready) check("csr_same_cycle_old", csr_read_data, m_csr[w][cur][0]);
            if (lanes.size() > 0 && !stamp_valid && !stamp_done) stalls++;
            @(posedge clk);
            if (lanes.size() > 0) begin
                if (stamp_valid) begin
                    model_write(w, cur, q.pop_front());
                    pops++;
                    void'(lanes.pop_front());
                end else if (stamp_done) begin
                    void'(lanes.pop_front());
                end
            end
        end
        check("latency", lat, 1 + k + stalls);
        check("pop_count", pops, used);
        check("rsp_wid", rsp_wid, w);
        check("rsp_tmask", rsp_tmask, tm);
        check("rsp_tag", rsp_tag, tag);
        check("rsp_data", rsp_data, exp_data);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            stamp_valid = (q.size() > 0);
            @(posedge clk);
            @(negedge clk);
            #1 check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_data", rsp_data, exp_data);
            check("hold_rsp_tag", rsp_tag, tag);
            check("hold_req_ready", req_ready, 0);
            check("hold_stamp_ready", stamp_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        stamp_valid = 1'b0;
        #1 check("after_rsp_valid", rsp_valid, 0);
        check("after_req_ready", req_ready, 1);
        q.delete();
        csr_sweep();
    endtask

    initial begin
        reset = 1'b1;
        stamp_valid = 1'b1; stamp_data = '0; stamp_done = 1'b0;
        req_valid = 1'b1; req_wid = '0; req_tmask = 4'hF; req_tag = '0;
        rsp_ready = 1'b0;
        csr_read_wid = '0; csr_read_lane = '0; csr_read_idx = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check("in_rst_req_ready", req_ready, 0);
        check("in_rst_stamp_ready", stamp_ready, 0);
        check("in_rst_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1 reset = 1'b0; req_valid = 1'b0; stamp_valid = 1'b0;
        @(negedge clk);
        #1 check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        csr_sweep();

        // All four lanes fed back-to-back.
        for (int n = 0; n < 4; n++) q.push_back(mk_stamp(14'(3 + n), 14'd5, 4'b1010));
        run_req(1, 4'b1111, 1'b0, 0, 0, 0, 0);
        csr_read_wid = 2'd1; csr_read_lane = 2'd2; csr_read_idx = 4'd0;
        #1 check("csr_1_2_pos_mask", csr_read_data, 32'h0014_005A);

        // Seed CSR[3][2], then a partial request where lane 2 sees done.
        q.push_back(mk_stamp(14'($urandom), 14'($urandom), 4'($urandom)));
        run_req(3, 4'b0100, 1'b0, 0, 0, 0, 0);
        q.push_back(mk_stamp(14'($urandom), 14'($urandom), 4'($urandom)));
        run_req(3, 4'b0101, 1'b0, 0, 0, 1, 0);

        // Three-cycle stall after the first pop.
        for (int n = 0; n < 3; n++) q.push_back(mk_stamp(14'($urandom), 14'($urandom), 4'($urandom)));
        run_req(0, 4'b1011, 1'b0, 1, 3, 0, 0);

        // Empty thread mask with a held response.
        q.push_back(mk_stamp(14'($urandom), 14'($urandom), 4'($urandom)));
        run_req(2, 4'b0000, 1'b0, 0, 0, 5, 0);

        // Reset after one of three pops.
        for (int n = 0; n < 3; n++) q.push_back(mk_stamp(14'($urandom), 14'($urandom), 4'($urandom)));
        run_req(2, 4'b0111, 1'b0, 0, 0, 0, 1);

        for (int t = 0; t < 40; t++) begin
            int nst;
            nst = $urandom_range(0, 5);
            for (int n = 0; n < nst; n++) q.push_back(mk_stamp(14'($urandom), 14'($urandom), 4'($urandom)));
            run_req($urandom_range(0, 3), 4'($urandom), 1'b1, 0, 0, $urandom_range(0, 3), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
